apb_bridge_master_arbiter: RTL and testbench

- Shares the single master port of the APB-to-APB bridge BFM (the PCLK_PM side) between NREQ independent requesters.
- Round-robin arbitration with an optional per-requester lock.
- Sequences the bridge handshake: SETUP, then a PENABLE rising edge, then a wait for the PREADY_PM pulse, then a mandatory PENABLE-low gap.
- Returns the read data and error to the winning requester, and runs a watchdog that flags a hung bridge.

---
 rtl/apb_arb_pkg.sv | 15 +
 rtl/rr_arbiter_core.sv | 51 +++++
 rtl/apb_bridge_master_arbiter.sv | 175 +++++++++++++++++
 tb/tb_apb_bridge_master_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB bridge master-port arbiter.
//   arb_state_e : transfer sequencer states (2 bits)
//   WdCntW      : width of the ACCESS-phase watchdog counter
package apb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StGap    = 2'd3
  } arb_state_e;

  localparam int unsigned WdCntW = 16;

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick with lock override.
// Ports:
//   i_valid    : per-requester request vector
//   i_ptr      : index with highest priority for this pick
//   i_lock     : lock flag from the last completed transfer
//   i_lock_id  : owner of the lock (index of the last grant)
//   o_gnt_oh   : one-hot grant (zero when nothing is valid)
//   o_gnt_id   : index of the granted requester
//   o_gnt_vld  : a winner exists
module rr_arbiter_core #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_lock,
  input  logic [IDW-1:0]  i_lock_id,
  output logic [NREQ-1:0] o_gnt_oh,
  output logic [IDW-1:0]  o_gnt_id,
  output logic            o_gnt_vld
);

  int unsigned    w_j;
  logic [IDW-1:0] w_jx;

  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_id  = '0;
    o_gnt_vld = 1'b0;
    w_j       = 0;
    w_jx      = '0;
    if (i_lock && i_valid[i_lock_id]) begin
      o_gnt_id  = i_lock_id;
      o_gnt_vld = 1'b1;
    end else begin
      // Scan upward from the pointer, wrapping at NREQ; first hit wins.
      for (int unsigned k = 0; k < NREQ; k++) begin
        w_j  = (32'(i_ptr) + k) % NREQ;
        w_jx = IDW'(w_j);
        if (!o_gnt_vld && i_valid[w_jx]) begin
          o_gnt_id  = w_jx;
          o_gnt_vld = 1'b1;
        end
      end
    end
    if (o_gnt_vld) begin
      o_gnt_oh[o_gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_bridge_master_arbiter.sv
// Shares the PCLK_PM master port of the APB-to-APB bridge between NREQ requesters.
// Round-robin arbitration with per-requester lock, SETUP/ACCESS/GAP sequencing,
// response routing back to the owner, and a sticky ACCESS-phase watchdog.
// Ports:
//   PCLK_PM, PRESETN_PM             : clock, async active-low reset
//   REQ_VALID/LOCK/WRITE/ADDR/WDATA : requester side (ADDR/WDATA flattened, 32b each)
//   REQ_READY                       : one-hot accept, combinational, IDLE only
//   RSP_VALID/RDATA/ERR             : one-cycle completion to the owner
//   PADDR/PWRITE/PENABLE/PWDATA_PM  : to bridge
//   PRDATA/PREADY/PSLVERR_PM        : from bridge (PREADY is a one-cycle pulse)
//   GRANT_ID, BUSY                  : current/last owner, state != IDLE
//   TIMEOUT, TIMEOUT_CLR            : sticky watchdog flag and its synchronous clear
module apb_bridge_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2,
  parameter int unsigned TO_CYCLES = 256
) (
  input  logic             PCLK_PM,
  input  logic             PRESETN_PM,
  input  logic [NREQ-1:0]  REQ_VALID,
  input  logic [NREQ-1:0]  REQ_LOCK,
  input  logic [NREQ-1:0]  REQ_WRITE,
  input  logic [NREQ*32-1:0] REQ_ADDR,
  input  logic [NREQ*32-1:0] REQ_WDATA,
  output logic [NREQ-1:0]  REQ_READY,
  output logic [NREQ-1:0]  RSP_VALID,
  output logic [31:0]      RSP_RDATA,
  output logic             RSP_ERR,
  output logic [31:0]      PADDR_PM,
  output logic             PWRITE_PM,
  output logic             PENABLE_PM,
  output logic [31:0]      PWDATA_PM,
  input  logic [31:0]      PRDATA_PM,
  input  logic             PREADY_PM,
  input  logic             PSLVERR_PM,
  output logic [IDW-1:0]   GRANT_ID,
  output logic             BUSY,
  output logic             TIMEOUT,
  input  logic             TIMEOUT_CLR
);

  // Counter value seen during the TO_CYCLES-th ACCESS cycle; TIMEOUT sets on that edge.
  localparam logic [WdCntW-1:0] ToLimM1 = (TO_CYCLES == 0) ? '0 : WdCntW'(TO_CYCLES - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [31:0]       r_paddr, r_pwdata, r_rsp_rdata;
  logic              r_pwrite, r_penable, r_rsp_err, r_lock, r_timeout;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [IDW-1:0]    r_grant_id, r_rr_ptr;
  logic [WdCntW-1:0] r_wd_cnt;

  logic [NREQ-1:0]   w_gnt_oh;
  logic [IDW-1:0]    w_gnt_id;
  logic              w_gnt_vld, w_accept, w_done, w_to_hit;

  rr_arbiter_core #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_valid   (REQ_VALID),
    .i_ptr     (r_rr_ptr),
    .i_lock    (r_lock),
    .i_lock_id (r_grant_id),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_id  (w_gnt_id),
    .o_gnt_vld (w_gnt_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = StSetup;
        end
      end
      StSetup:  w_state_nxt = StAccess;
      StAccess: begin
        if (PREADY_PM) begin
          w_done      = 1'b1;
          w_state_nxt = StGap;
        end
      end
      StGap:    w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  assign w_to_hit = (TO_CYCLES != 0) && (r_state == StAccess) && (r_wd_cnt == ToLimM1);

  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_paddr    <= REQ_ADDR[w_gnt_id*32 +: 32];
        r_pwdata   <= REQ_WDATA[w_gnt_id*32 +: 32];
        r_pwrite   <= REQ_WRITE[w_gnt_id];
        r_grant_id <= w_gnt_id;
        r_rr_ptr   <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end

      // A stale lock whose owner has gone quiet is dropped so plain round-robin resumes.
      if (r_state == StIdle && r_lock && !REQ_VALID[r_grant_id]) begin
        r_lock <= 1'b0;
      end

      if (r_state == StSetup) begin
        r_penable <= 1'b1;
      end

      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? 32'h0 : PRDATA_PM;
        r_rsp_err   <= PSLVERR_PM;
        r_rsp_valid <= NREQ'(1) << r_grant_id;
        r_penable   <= 1'b0;
        r_lock      <= REQ_LOCK[r_grant_id];
      end else if (r_state == StGap) begin
        r_rsp_valid <= '0;
      end

      if (r_state == StAccess) begin
        if (r_wd_cnt != '1) begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end else if (r_state == StGap) begin
        r_wd_cnt <= '0;
      end

      // Set has priority over clear.
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end else if (TIMEOUT_CLR) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign REQ_READY  = (r_state == StIdle) ? w_gnt_oh : '0;
  assign BUSY       = (r_state != StIdle);
  assign RSP_VALID  = r_rsp_valid;
  assign RSP_RDATA  = r_rsp_rdata;
  assign RSP_ERR    = r_rsp_err;
  assign PADDR_PM   = r_paddr;
  assign PWDATA_PM  = r_pwdata;
  assign PWRITE_PM  = r_pwrite;
  assign PENABLE_PM = r_penable;
  assign GRANT_ID   = r_grant_id;
  assign TIMEOUT    = r_timeout;

endmodule

// File: tb/tb_apb_bridge_master_arbiter.sv
// Scoreboard bench for apb_bridge_master_arbiter (NREQ=4, TO_CYCLES=16).
// Requesters and a behavioural bridge are driven 1ns after the rising edge; the
// monitor samples on the falling edge, pushes expectations at accept and pops them
// at completion.
module tb_apb_bridge_master_arbiter;

  localparam int NREQ = 4;

  logic              PCLK_PM = 1'b0;
  logic              PRESETN_PM;
  logic [NREQ-1:0]   REQ_VALID, REQ_LOCK, REQ_WRITE, REQ_READY, RSP_VALID;
  logic [NREQ*32-1:0] REQ_ADDR, REQ_WDATA;
  logic [31:0]       RSP_RDATA, PADDR_PM, PWDATA_PM, PRDATA_PM;
  logic              RSP_ERR, PWRITE_PM, PENABLE_PM, PREADY_PM, PSLVERR_PM;
  logic [1:0]        GRANT_ID;
  logic              BUSY, TIMEOUT, TIMEOUT_CLR;

  apb_bridge_master_arbiter #(
    .NREQ      (4),
    .IDW       (2),
    .TO_CYCLES (16)
  ) dut (
    .PCLK_PM     (PCLK_PM),
    .PRESETN_PM  (PRESETN_PM),
    .REQ_VALID   (REQ_VALID),
    .REQ_LOCK    (REQ_LOCK),
    .REQ_WRITE   (REQ_WRITE),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_WDATA   (REQ_WDATA),
    .REQ_READY   (REQ_READY),
    .RSP_VALID   (RSP_VALID),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_ERR     (RSP_ERR),
    .PADDR_PM    (PADDR_PM),
    .PWRITE_PM   (PWRITE_PM),
    .PENABLE_PM  (PENABLE_PM),
    .PWDATA_PM   (PWDATA_PM),
    .PRDATA_PM   (PRDATA_PM),
    .PREADY_PM   (PREADY_PM),
    .PSLVERR_PM  (PSLVERR_PM),
    .GRANT_ID    (GRANT_ID),
    .BUSY        (BUSY),
    .TIMEOUT     (TIMEOUT),
    .TIMEOUT_CLR (TIMEOUT_CLR)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          gnt_q[$];
  exp_t        mon_e;
  int          mon_idx;
  int          remaining[NREQ];
  bit          lock_en[NREQ];
  bit          wr_en[NREQ];
  logic [31:0] req_addr[NREQ];
  logic [31:0] req_wdata[NREQ];
  int          cfg_lat;
  logic [31:0] cfg_prdata;
  logic        cfg_err;
  bit          wd_mode;
  int          cyc, acc_cyc, acc_m, br_n;
  logic [NREQ-1:0] prev_rsp;
  int          n_chk, n_fail;

  always #5 PCLK_PM = ~PCLK_PM;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge PCLK_PM);
    #2;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      done = (sb_q.size() == 0) && (gnt_q.size() == 0) && !BUSY;
      for (int i = 0; i < NREQ; i++) begin
        if (remaining[i] != 0) done = 1'b0;
      end
    end
    check_eq(tag, 64'(done), 64'(1));
  endtask

  // Requester driver: valid while transfers remain; payload from the per-requester arrays.
  initial begin : drv
    forever begin
      @(posedge PCLK_PM);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        REQ_VALID[i]          = (remaining[i] > 0);
        REQ_LOCK[i]           = lock_en[i] && (remaining[i] > 0);
        REQ_WRITE[i]          = wr_en[i];
        REQ_ADDR[32*i +: 32]  = req_addr[i];
        REQ_WDATA[32*i +: 32] = req_wdata[i];
      end
    end
  end

  // Bridge model: PREADY pulse in the cfg_lat-th cycle of PENABLE high.
  initial begin : bridge
    forever begin
      @(posedge PCLK_PM);
      #1;
      PREADY_PM  = 1'b0;
      PRDATA_PM  = cfg_prdata;
      PSLVERR_PM = cfg_err;
      if (PENABLE_PM && PRESETN_PM) begin
        br_n++;
        if (br_n == cfg_lat) PREADY_PM = 1'b1;
      end else begin
        br_n = 0;
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge PCLK_PM);
      cyc++;
      if (!PRESETN_PM) begin
        acc_m    = 0;
        prev_rsp = '0;
      end else begin
        if (REQ_READY != '0) begin
          check_eq("ready_onehot", 64'($countones(REQ_READY)), 64'(1));
          mon_idx = -1;
          for (int i = 0; i < NREQ; i++) begin
            if (REQ_READY[i] && mon_idx < 0) mon_idx = i;
          end
          if (gnt_q.size() == 0) begin
            check_eq("acc_unexpected", 64'(REQ_READY), 64'(0));
          end else begin
            check_eq("grant_order", 64'(mon_idx), 64'(gnt_q.pop_front()));
            check_eq("idle_penable_low", 64'(PENABLE_PM), 64'(0));
            check_eq("idle_busy", 64'(BUSY), 64'(0));
            mon_e.id    = 2'(mon_idx);
            mon_e.addr  = req_addr[mon_idx];
            mon_e.wdata = req_wdata[mon_idx];
            mon_e.wr    = wr_en[mon_idx];
            mon_e.rdata = wr_en[mon_idx] ? 32'h0 : cfg_prdata;
            mon_e.err   = cfg_err;
            sb_q.push_back(mon_e);
            if (remaining[mon_idx] > 0) remaining[mon_idx]--;
            // Scramble the payload after accept; the DUT must hold the captured copy.
            req_addr[mon_idx]  = req_addr[mon_idx] + 32'h10;
            req_wdata[mon_idx] = ~req_wdata[mon_idx];
          end
          acc_cyc = cyc;
        end

        if (PENABLE_PM) acc_m++;
        else acc_m = 0;
        if (acc_m == 1) begin
          check_eq("penable_latency", 64'(cyc - acc_cyc), 64'(2));
          check_eq("access_busy", 64'(BUSY), 64'(1));
          if (sb_q.size() > 0) begin
            check_eq("paddr", 64'(PADDR_PM), 64'(sb_q[0].addr));
            check_eq("pwdata", 64'(PWDATA_PM), 64'(sb_q[0].wdata));
            check_eq("pwrite", 64'(PWRITE_PM), 64'(sb_q[0].wr));
            check_eq("grant_id", 64'(GRANT_ID), 64'(sb_q[0].id));
          end
        end
        if (wd_mode && (acc_m == 16 || acc_m == 17)) begin
          check_eq("timeout_edge", 64'(TIMEOUT), 64'(acc_m == 17));
        end

        if (RSP_VALID != '0) begin
          check_eq("rsp_single_cycle", 64'(prev_rsp), 64'(0));
          if (sb_q.size() == 0) begin
            check_eq("rsp_unexpected", 64'(RSP_VALID), 64'(0));
          end else begin
            mon_e = sb_q.pop_front();
            check_eq("rsp_owner", 64'(RSP_VALID), 64'(4'(1) << mon_e.id));
            check_eq("rsp_rdata", 64'(RSP_RDATA), 64'(mon_e.rdata));
            check_eq("rsp_err", 64'(RSP_ERR), 64'(mon_e.err));
          end
        end
        prev_rsp = RSP_VALID;
      end
    end
  end

  initial begin : main
    PRESETN_PM  = 1'b0;
    TIMEOUT_CLR = 1'b0;
    REQ_VALID   = '0;
    REQ_LOCK    = '0;
    REQ_WRITE   = '0;
    REQ_ADDR    = '0;
    REQ_WDATA   = '0;
    PREADY_PM   = 1'b0;
    PRDATA_PM   = '0;
    PSLVERR_PM  = 1'b0;
    cfg_lat     = 1;
    cfg_prdata  = 32'hA5A5_0F0F;
    cfg_err     = 1'b0;
    wd_mode     = 1'b0;
    prev_rsp    = '0;
    for (int i = 0; i < NREQ; i++) begin
      remaining[i] = 0;
      lock_en[i]   = 1'b0;
      wr_en[i]     = 1'b0;
      req_addr[i]  = 32'h2000_0000 + 32'(i) * 32'h100;
      req_wdata[i] = 32'h5000_0000 + 32'(i);
    end
    repeat (3) tick();
    check_eq("rst_bus", {PADDR_PM, PWDATA_PM}, 64'(0));
    check_eq("rst_ctl", 64'({PWRITE_PM, PENABLE_PM, RSP_VALID, RSP_ERR, GRANT_ID, BUSY, TIMEOUT}),
             64'(0));
    check_eq("rst_rdata", 64'(RSP_RDATA), 64'(0));
    PRESETN_PM = 1'b1;
    tick();

    // Round-robin: everyone valid for two transfers each.
    for (int i = 0; i < NREQ; i++) begin
      wr_en[i]     = i[0];
      remaining[i] = 2;
    end
    for (int k = 0; k < 8; k++) gnt_q.push_back(k % 4);
    wait_done("rr_done", 200);

    // Single write from requester 0.
    wr_en[0]     = 1'b1;
    req_addr[0]  = 32'h0100_0004;
    req_wdata[0] = 32'hDEAD_BEEF;
    remaining[0] = 1;
    gnt_q.push_back(0);
    wait_done("wr_done", 50);

    // Read with slave error from requester 1.
    wr_en[1]     = 1'b0;
    cfg_prdata   = 32'h1234_5678;
    cfg_err      = 1'b1;
    remaining[1] = 1;
    gnt_q.push_back(1);
    wait_done("rderr_done", 50);
    cfg_err = 1'b0;

    // Lock: requester 2 holds three transfers while 0 and 3 wait.
    lock_en[2]   = 1'b1;
    remaining[2] = 3;
    remaining[0] = 1;
    remaining[3] = 1;
    wr_en[2]     = 1'b1;
    gnt_q.push_back(2);
    gnt_q.push_back(2);
    gnt_q.push_back(2);
    gnt_q.push_back(3);
    gnt_q.push_back(0);
    wait_done("lock_done", 200);
    lock_en[2] = 1'b0;

    // Watchdog: 40-cycle stall on a read.
    wd_mode      = 1'b1;
    cfg_lat      = 40;
    cfg_prdata   = 32'hCAFE_0001;
    wr_en[3]     = 1'b0;
    remaining[3] = 1;
    gnt_q.push_back(3);
    wait_done("wd_done", 200);
    wd_mode = 1'b0;
    check_eq("timeout_sticky", 64'(TIMEOUT), 64'(1));
    TIMEOUT_CLR = 1'b1;
    #1;
    check_eq("timeout_clr_sync", 64'(TIMEOUT), 64'(1));
    tick();
    TIMEOUT_CLR = 1'b0;
    check_eq("timeout_cleared", 64'(TIMEOUT), 64'(0));

    // Reset in the middle of ACCESS.
    cfg_lat      = 10;
    wr_en[2]     = 1'b0;
    remaining[2] = 1;
    gnt_q.push_back(2);
    for (int c = 0; c < 50 && !PENABLE_PM; c++) tick();
    check_eq("rm_reached_access", 64'(PENABLE_PM), 64'(1));
    PRESETN_PM = 1'b0;
    #1;
    check_eq("rm_bus", {PADDR_PM, PWDATA_PM}, 64'(0));
    check_eq("rm_ctl", 64'({PWRITE_PM, PENABLE_PM, RSP_VALID, RSP_ERR, GRANT_ID, BUSY, TIMEOUT}),
             64'(0));
    check_eq("rm_rdata", 64'(RSP_RDATA), 64'(0));
    sb_q.delete();
    gnt_q.delete();
    for (int i = 0; i < NREQ; i++) remaining[i] = 0;
    tick();
    tick();
    PRESETN_PM = 1'b1;
    cfg_lat    = 1;
    for (int i = 0; i < NREQ; i++) begin
      remaining[i] = 1;
      gnt_q.push_back(i);
    end
    wait_done("post_rst_done", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
